// File: rtl/alu_multiply_sequencer.sv
// Unsigned 16x16->32 shift-and-add multiplier that borrows the shared ALU while Busy.
// Fixed 36-cycle Start-to-IDLE latency; Start is only honoured in IDLE, never queued.
module alu_multiply_sequencer #(
  parameter int ITER = 16
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [15:0] Multiplicand,
  input  logic [15:0] Multiplier,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Product,
  output logic        ProdZ,
  output logic        ProdN,
  output logic [31:0] AluA,
  output logic [31:0] AluB,
  output logic [4:0]  AluFunSel,
  output logic        AluWF,
  input  logic [31:0] AluOut,
  input  logic [3:0]  AluFlags
);

  localparam logic [4:0] FS_PASS = 5'b10000;
  localparam logic [4:0] FS_ADD  = 5'b10100;
  localparam logic [4:0] FS_LSL  = 5'b11011;
  localparam logic [4:0] LAST    = 5'(ITER - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADD, S_SHIFT, S_FLAG, S_LATCH, S_DONE
  } state_t;

  state_t      state, next_state;
  logic [31:0] acc;
  logic [31:0] mcand;
  logic [15:0] mplier;
  logic [4:0]  cnt;

  // C and O cannot matter for an unsigned 16x16 product
  logic unused_flags;
  assign unused_flags = ^{AluFlags[2], AluFlags[0]};

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    AluA       = '0;
    AluB       = '0;
    AluFunSel  = FS_PASS;
    AluWF      = 1'b0;
    case (state)
      S_IDLE: if (Start) next_state = S_ADD;
      S_ADD: begin
        AluA       = acc;
        AluB       = mcand;
        AluFunSel  = mplier[0] ? FS_ADD : FS_PASS;
        next_state = S_SHIFT;
      end
      S_SHIFT: begin
        AluA       = mcand;
        AluFunSel  = FS_LSL;
        next_state = (cnt == LAST) ? S_FLAG : S_ADD;
      end
      S_FLAG: begin
        // pass-through with WF so the ALU's Z/N describe the product
        AluA       = acc;
        AluWF      = 1'b1;
        next_state = S_LATCH;
      end
      S_LATCH: next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  assign Busy = (state != S_IDLE);
  assign Done = (state == S_DONE);

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      Product <= '0;
      ProdZ   <= 1'b0;
      ProdN   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (Start) begin
          acc    <= '0;
          mcand  <= {16'b0, Multiplicand};
          mplier <= Multiplier;
          cnt    <= '0;
        end
        S_ADD: acc <= AluOut;
        S_SHIFT: begin
          mcand  <= AluOut;
          mplier <= mplier >> 1;
          cnt    <= cnt + 5'd1;
        end
        S_LATCH: begin
          Product <= acc;
          ProdZ   <= AluFlags[3];
          ProdN   <= AluFlags[1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_multiply_sequencer.sv
// Directed bench for alu_multiply_sequencer with a behavioural model of the shared ALU.
module tb_alu_multiply_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic [15:0] Multiplicand;
  logic [15:0] Multiplier;
  logic        Busy;
  logic        Done;
  logic [31:0] Product;
  logic        ProdZ;
  logic        ProdN;
  logic [31:0] AluA;
  logic [31:0] AluB;
  logic [4:0]  AluFunSel;
  logic        AluWF;
  logic [31:0] AluOut;
  logic [3:0]  AluFlags;

  int checks = 0;
  int errors = 0;
  int gcyc   = 0;
  int last_done_cyc = 0;

  alu_multiply_sequencer dut (
    .Clock(Clock), .Reset(Reset), .Start(Start),
    .Multiplicand(Multiplicand), .Multiplier(Multiplier),
    .Busy(Busy), .Done(Done), .Product(Product), .ProdZ(ProdZ), .ProdN(ProdN),
    .AluA(AluA), .AluB(AluB), .AluFunSel(AluFunSel), .AluWF(AluWF),
    .AluOut(AluOut), .AluFlags(AluFlags)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) gcyc <= gcyc + 1;

  // ALU model: only the 32-bit functions the sequencer uses
  always_comb begin
    AluOut = 32'h0;
    case (AluFunSel)
      5'b10000: AluOut = AluA;
      5'b10100: AluOut = AluA + AluB;
      5'b11011: AluOut = AluA << 1;
      default:  AluOut = 32'h0;
    endcase
  end

  always @(posedge Clock or negedge Reset) begin
    if (!Reset)     AluFlags <= 4'h0;
    else if (AluWF) AluFlags <= {AluOut == 32'h0, 1'b0, AluOut[31], 1'b0};
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Called in an IDLE cycle (1 ns after the edge); returns in cycle 36.
  task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] exp_p, input logic ez, input logic en,
                        input bit repulse);
    int wf_n = 0, wf_at = 0, done_n = 0, done_at = 0, busy_bad = 0, fs_bad = 0;
    logic [31:0] flag_a = 32'h0;
    logic [4:0]  exp_fs;
    Multiplicand = a;
    Multiplier   = b;
    Start        = 1'b1;
    tick();
    Start = 1'b0;
    for (int c = 1; c <= 35; c++) begin
      if (repulse && (c == 5 || c == 35)) begin
        Multiplicand = 16'hFFFF;
        Multiplier   = 16'hFFFF;
        Start        = 1'b1;
      end
      if (!Busy) busy_bad++;
      if (AluWF) begin wf_n++; wf_at = c; end
      if (Done) begin done_n++; done_at = c; last_done_cyc = gcyc; end
      if (c <= 32) begin
        if (c % 2 == 1) exp_fs = b[(c - 1) / 2] ? 5'b10100 : 5'b10000;
        else            exp_fs = 5'b11011;
        if (AluFunSel !== exp_fs) fs_bad++;
      end
      if (c == 33) flag_a = AluA;
      tick();
      Start = 1'b0;
    end
    check({tag, "_busy_window"}, 32'(busy_bad), 32'd0);
    check({tag, "_idle_after"},  {31'b0, Busy}, 32'd0);
    check({tag, "_funsel_seq"},  32'(fs_bad),   32'd0);
    check({tag, "_wf_count"},    32'(wf_n),     32'd1);
    check({tag, "_wf_cycle"},    32'(wf_at),    32'd33);
    check({tag, "_done_count"},  32'(done_n),   32'd1);
    check({tag, "_done_cycle"},  32'(done_at),  32'd35);
    check({tag, "_flag_alua"},   flag_a,        exp_p);
    check({tag, "_product"},     Product,       exp_p);
    check({tag, "_prodz"},       {31'b0, ProdZ}, {31'b0, ez});
    check({tag, "_prodn"},       {31'b0, ProdN}, {31'b0, en});
  endtask

  initial begin
    int t1;
    Reset = 1'b0;
    Start = 1'b0;
    Multiplicand = 16'h0;
    Multiplier   = 16'h0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst_busy",    {31'b0, Busy},    32'd0);
    check("rst_done",    {31'b0, Done},    32'd0);
    check("rst_product", Product,          32'd0);
    check("rst_funsel",  {27'b0, AluFunSel}, 32'h10);
    check("rst_wf",      {31'b0, AluWF},   32'd0);
    check("rst_alua",    AluA,             32'd0);
    Reset = 1'b1;
    tick();

    run_op("m3x5",     16'h0003, 16'h0005, 32'h0000000F, 1'b0, 1'b0, 1'b0);
    run_op("zero",     16'h1234, 16'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0);
    run_op("ffffsq",   16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, 1'b1, 1'b0);

    // reset in cycle 10 of an operation
    Multiplicand = 16'h00FF;
    Multiplier   = 16'h0101;
    Start        = 1'b1;
    tick();
    Start = 1'b0;
    repeat (9) tick();
    #2;
    Reset = 1'b0;
    #1;
    check("mid_rst_busy",    {31'b0, Busy},  32'd0);
    check("mid_rst_done",    {31'b0, Done},  32'd0);
    check("mid_rst_product", Product,        32'd0);
    check("mid_rst_prodn",   {31'b0, ProdN}, 32'd0);
    check("mid_rst_funsel",  {27'b0, AluFunSel}, 32'h10);
    check("mid_rst_alua",    AluA,           32'd0);
    check("mid_rst_alub",    AluB,           32'd0);
    check("mid_rst_wf",      {31'b0, AluWF}, 32'd0);
    @(posedge Clock);
    #1;
    Reset = 1'b1;
    tick();
    run_op("post_rst", 16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0, 1'b0, 1'b0);

    run_op("repulse",  16'h0007, 16'h0009, 32'h0000003F, 1'b0, 1'b0, 1'b1);
    // accepted straight away in cycle 36 of the previous operation
    run_op("b2b_a",    16'h8000, 16'h0002, 32'h00010000, 1'b0, 1'b0, 1'b0);
    t1 = last_done_cyc;
    run_op("b2b_b",    16'h0001, 16'h0001, 32'h00000001, 1'b0, 1'b0, 1'b0);
    check("b2b_done_spacing", 32'(last_done_cyc - t1), 32'd36);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
